// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and sequencing controller for the 5-stage RV32I pipeline.
//
// Drives the stall/flush controls of the F/D/E/M/W pipeline registers and the
// E-stage forwarding mux selects. It also holds the pipeline flushed for a few
// cycles after reset and freezes it while data memory inserts wait states. A
// wait that runs too long halts the pipeline until the next reset. Two
// saturating counters record stall and branch-flush cycles for performance
// debug.
//
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   Rs1D_i, Rs2D_i                  source registers of the instruction in D
//   Rs1E_i, Rs2E_i                  source registers of the instruction in E
//   RdE_i, RdM_i, RdW_i             destination registers in E/M/W
//   LoadE_i                         instruction in E is a load
//   RegWriteM_i, RegWriteW_i        register write enables in M/W
//   PCSrcE_i                        branch taken / jump resolved in E
//   MemReqM_i, MemReadyM_i          data-memory request in M / access completes
//   StallF_o..StallM_o              hold the stage register
//   FlushD_o, FlushE_o, FlushW_o    insert a bubble into F/D, D/E, M/W
//   ForwardAE_o, ForwardBE_o        00 regfile, 01 W result, 10 M ALU result
//   MemTimeout_o                    sticky: memory wait exceeded MAX_WAIT
//   StallCount_o, FlushCount_o      saturating performance counters
module hazard_ctrl #(
  parameter int unsigned REGISTER_ADDRESS_WIDTH = 5,
  parameter int unsigned STARTUP_CYCLES         = 2,
  parameter int unsigned MAX_WAIT               = 16,
  parameter int unsigned COUNT_WIDTH            = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW_i,
  input  logic                              LoadE_i,
  input  logic                              RegWriteM_i,
  input  logic                              RegWriteW_i,
  input  logic                              PCSrcE_i,
  input  logic                              MemReqM_i,
  input  logic                              MemReadyM_i,
  output logic                              StallF_o,
  output logic                              StallD_o,
  output logic                              StallE_o,
  output logic                              StallM_o,
  output logic                              FlushD_o,
  output logic                              FlushE_o,
  output logic                              FlushW_o,
  output logic [1:0]                        ForwardAE_o,
  output logic [1:0]                        ForwardBE_o,
  output logic                              MemTimeout_o,
  output logic [COUNT_WIDTH-1:0]            StallCount_o,
  output logic [COUNT_WIDTH-1:0]            FlushCount_o
);

  localparam int unsigned SW = (STARTUP_CYCLES < 1) ? 1 : $clog2(STARTUP_CYCLES + 1);
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    ST_STARTUP,
    ST_RUN,
    ST_MEM_WAIT,
    ST_HALT
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [SW-1:0]          r_startup_cnt;
  logic [SW-1:0]          w_startup_next;
  logic [WW-1:0]          r_wait_cnt;
  logic [WW-1:0]          w_wait_next;
  logic                   r_timeout;
  logic                   w_timeout_set;
  logic                   w_flush_evt;
  logic                   w_stall_evt;
  logic [COUNT_WIDTH-1:0] r_stall_cnt;
  logic [COUNT_WIDTH-1:0] r_flush_cnt;
  logic                   w_mem_wait;
  logic                   w_load_use;

  assign w_mem_wait = MemReqM_i & ~MemReadyM_i;
  assign w_load_use = LoadE_i && (RdE_i != '0) && ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));

  always_comb begin
    w_state_next   = r_state;
    w_startup_next = r_startup_cnt;
    w_wait_next    = r_wait_cnt;
    w_timeout_set  = 1'b0;
    w_flush_evt    = 1'b0;
    StallF_o       = 1'b0;
    StallD_o       = 1'b0;
    StallE_o       = 1'b0;
    StallM_o       = 1'b0;
    FlushD_o       = 1'b0;
    FlushE_o       = 1'b0;
    FlushW_o       = 1'b0;
    unique case (r_state)
      ST_STARTUP: begin
        StallF_o = 1'b1;
        FlushD_o = 1'b1;
        FlushE_o = 1'b1;
        FlushW_o = 1'b1;
        w_startup_next = r_startup_cnt + SW'(1);
        if (32'(r_startup_cnt) + 32'd1 >= STARTUP_CYCLES) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_mem_wait) begin
          {StallF_o, StallD_o, StallE_o, StallM_o, FlushW_o} = '1;
          w_state_next = ST_MEM_WAIT;
          w_wait_next  = WW'(1);
        end else if (PCSrcE_i) begin
          // Wrong-path instruction in D makes any load-use stall moot.
          FlushD_o    = 1'b1;
          FlushE_o    = 1'b1;
          w_flush_evt = 1'b1;
        end else if (w_load_use) begin
          StallF_o = 1'b1;
          StallD_o = 1'b1;
          FlushE_o = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        // Ready releases the freeze in the same cycle it arrives.
        if (MemReadyM_i) begin
          w_state_next = ST_RUN;
          w_wait_next  = '0;
        end else begin
          {StallF_o, StallD_o, StallE_o, StallM_o, FlushW_o} = '1;
          w_wait_next = r_wait_cnt + WW'(1);
          if (32'(r_wait_cnt) + 32'd1 >= MAX_WAIT) begin
            w_state_next  = ST_HALT;
            w_timeout_set = 1'b1;
          end
        end
      end
      ST_HALT: begin
        {StallF_o, StallD_o, StallE_o, StallM_o, FlushW_o} = '1;
      end
      default: w_state_next = ST_STARTUP;
    endcase
  end

  assign w_stall_evt = StallD_o && ((r_state == ST_RUN) || (r_state == ST_MEM_WAIT));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= ST_STARTUP;
      r_startup_cnt <= '0;
      r_wait_cnt    <= '0;
      r_timeout     <= 1'b0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else begin
      r_state       <= w_state_next;
      r_startup_cnt <= w_startup_next;
      r_wait_cnt    <= w_wait_next;
      if (w_timeout_set) r_timeout <= 1'b1;
      if (w_stall_evt && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_evt && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  // M is the younger producer, so it takes priority over W; x0 never forwards.
  always_comb begin
    ForwardAE_o = 2'b00;
    ForwardBE_o = 2'b00;
    if (RegWriteM_i && (RdM_i != '0) && (RdM_i == Rs1E_i))      ForwardAE_o = 2'b10;
    else if (RegWriteW_i && (RdW_i != '0) && (RdW_i == Rs1E_i)) ForwardAE_o = 2'b01;
    if (RegWriteM_i && (RdM_i != '0) && (RdM_i == Rs2E_i))      ForwardBE_o = 2'b10;
    else if (RegWriteW_i && (RdW_i != '0) && (RdW_i == Rs2E_i)) ForwardBE_o = 2'b01;
  end

  assign MemTimeout_o = r_timeout;
  assign StallCount_o = r_stall_cnt;
  assign FlushCount_o = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
  logic       LoadE = 1'b0, RegWriteM = 1'b0, RegWriteW = 1'b0, PCSrcE = 1'b0;
  logic       MemReq = 1'b0, MemReady = 1'b0;

  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
  logic [1:0]  FwdA, FwdB;
  logic [15:0] StallCnt, FlushCnt;

  logic        s_StallF, s_StallD, s_StallE, s_StallM, s_FlushD, s_FlushE, s_FlushW, s_MemTimeout;
  logic [1:0]  s_FwdA, s_FwdB;
  logic [1:0]  s_StallCnt, s_FlushCnt;

  always #5 clk = ~clk;

  hazard_ctrl u_dut (
    .clk_i(clk), .rst_i(rst),
    .Rs1D_i(Rs1D), .Rs2D_i(Rs2D), .Rs1E_i(Rs1E), .Rs2E_i(Rs2E),
    .RdE_i(RdE), .RdM_i(RdM), .RdW_i(RdW),
    .LoadE_i(LoadE), .RegWriteM_i(RegWriteM), .RegWriteW_i(RegWriteW),
    .PCSrcE_i(PCSrcE), .MemReqM_i(MemReq), .MemReadyM_i(MemReady),
    .StallF_o(StallF), .StallD_o(StallD), .StallE_o(StallE), .StallM_o(StallM),
    .FlushD_o(FlushD), .FlushE_o(FlushE), .FlushW_o(FlushW),
    .ForwardAE_o(FwdA), .ForwardBE_o(FwdB), .MemTimeout_o(MemTimeout),
    .StallCount_o(StallCnt), .FlushCount_o(FlushCnt)
  );

  // Narrow-counter copy to reach saturation within a short run.
  hazard_ctrl #(.COUNT_WIDTH(2)) u_sat (
    .clk_i(clk), .rst_i(rst),
    .Rs1D_i(Rs1D), .Rs2D_i(Rs2D), .Rs1E_i(Rs1E), .Rs2E_i(Rs2E),
    .RdE_i(RdE), .RdM_i(RdM), .RdW_i(RdW),
    .LoadE_i(LoadE), .RegWriteM_i(RegWriteM), .RegWriteW_i(RegWriteW),
    .PCSrcE_i(PCSrcE), .MemReqM_i(MemReq), .MemReadyM_i(MemReady),
    .StallF_o(s_StallF), .StallD_o(s_StallD), .StallE_o(s_StallE), .StallM_o(s_StallM),
    .FlushD_o(s_FlushD), .FlushE_o(s_FlushE), .FlushW_o(s_FlushW),
    .ForwardAE_o(s_FwdA), .ForwardBE_o(s_FwdB), .MemTimeout_o(s_MemTimeout),
    .StallCount_o(s_StallCnt), .FlushCount_o(s_FlushCnt)
  );

  typedef struct packed {
    logic        rst;
    logic [4:0]  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic        loade, rwm, rww, pcsrc, req, rdy;
  } stim_t;

  typedef struct packed {
    logic [6:0]  ctl;   // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    logic [1:0]  fa, fb;
    logic        to;
    logic [15:0] sc, fc;
  } exp_t;

  localparam logic [6:0] C_START = 7'b1000_111;
  localparam logic [6:0] C_RUN   = 7'b0000_000;
  localparam logic [6:0] C_MEMW  = 7'b1111_001;
  localparam logic [6:0] C_LU    = 7'b1100_010;
  localparam logic [6:0] C_BR    = 7'b0000_110;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic exp_t E(logic [6:0] c, logic [1:0] a, logic [1:0] b, logic t,
                             logic [15:0] s, logic [15:0] f);
    exp_t r;
    r.ctl = c; r.fa = a; r.fb = b; r.to = t; r.sc = s; r.fc = f;
    return r;
  endfunction

  function automatic exp_t obs();
    return exp_t'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                   FwdA, FwdB, MemTimeout, StallCnt, FlushCnt});
  endfunction

  task automatic drive(input stim_t s);
    @(negedge clk);
    rst = s.rst; Rs1D = s.rs1d; Rs2D = s.rs2d; Rs1E = s.rs1e; Rs2E = s.rs2e;
    RdE = s.rde; RdM = s.rdm; RdW = s.rdw; LoadE = s.loade; RegWriteM = s.rwm;
    RegWriteW = s.rww; PCSrcE = s.pcsrc; MemReq = s.req; MemReady = s.rdy;
  endtask

  task automatic test_reset();
    stim_t st[2]; exp_t got, e;
    foreach (st[i]) begin st[i] = '0; st[i].rst = 1'b1; end
    st[1].loade = 1; st[1].rde = 5; st[1].rs1d = 5; st[1].pcsrc = 1; st[1].req = 1;
    for (int i = 0; i < 2; i++) begin
      drive(st[i]); sb.push_back(E(C_START, 2'b00, 2'b00, 1'b0, 16'd0, 16'd0)); #2;
      got = obs(); e = sb.pop_front(); n_vec++;
      if (got !== e) begin n_miss++; $display("FAIL reset[%0d]: got=%h want=%h", i, got, e); end
    end
  endtask

  task automatic test_startup();
    stim_t st[3]; exp_t ex[3]; exp_t got, e;
    foreach (st[i]) st[i] = '0;
    st[0].pcsrc = 1; st[0].req = 1;
    ex[0] = E(C_START, 2'b00, 2'b00, 1'b0, 16'd0, 16'd0);
    ex[1] = E(C_START, 2'b00, 2'b00, 1'b0, 16'd0, 16'd0);
    ex[2] = E(C_RUN,   2'b00, 2'b00, 1'b0, 16'd0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      drive(st[i]); sb.push_back(ex[i]); #2;
      got = obs(); e = sb.pop_front(); n_vec++;
      if (got !== e) begin n_miss++; $display("FAIL startup[%0d]: got=%h want=%h", i, got, e); end
    end
  endtask

  task automatic test_load_use();
    stim_t st[5]; exp_t ex[5]; exp_t got, e;
    foreach (st[i]) st[i] = '0;
    st[0].loade = 1; st[0].rde = 5; st[0].rs1d = 5;
    st[2].loade = 1; st[2].rde = 0; st[2].rs1d = 0;
    st[3].loade = 1; st[3].rde = 5; st[3].rs2d = 5;
    ex[0] = E(C_LU,  2'b00, 2'b00, 1'b0, 16'd0, 16'd0);
    ex[1] = E(C_RUN, 2'b00, 2'b00, 1'b0, 16'd1, 16'd0);
    ex[2] = E(C_RUN, 2'b00, 2'b00, 1'b0, 16'd1, 16'd0);
    ex[3] = E(C_LU,  2'b00, 2'b00, 1'b0, 16'd1, 16'd0);
    ex[4] = E(C_RUN, 2'b00, 2'b00, 1'b0, 16'd2, 16'd0);
    for (int i = 0; i < 5; i++) begin
      drive(st[i]); sb.push_back(ex[i]); #2;
      got = obs(); e = sb.pop_front(); n_vec++;
      if (got !== e) begin n_miss++; $display("FAIL load_use[%0d]: got=%h want=%h", i, got, e); end
    end
  endtask

  task automatic test_branch();
    stim_t st[2]; exp_t ex[2]; exp_t got, e;
    foreach (st[i]) st[i] = '0;
    st[0].loade = 1; st[0].rde = 5; st[0].rs2d = 5; st[0].pcsrc = 1;
    ex[0] = E(C_BR,  2'b00, 2'b00, 1'b0, 16'd2, 16'd0);
    ex[1] = E(C_RUN, 2'b00, 2'b00, 1'b0, 16'd2, 16'd1);
    for (int i = 0; i < 2; i++) begin
      drive(st[i]); sb.push_back(ex[i]); #2;
      got = obs(); e = sb.pop_front(); n_vec++;
      if (got !== e) begin n_miss++; $display("FAIL branch[%0d]: got=%h want=%h", i, got, e); end
    end
  endtask

  task automatic test_forward();
    stim_t st[6]; logic [1:0] fa[6], fb[6]; exp_t got, e;
    foreach (st[i]) st[i] = '0;
    st[0].rs1e = 3; st[0].rdm = 3; st[0].rwm = 1; st[0].rdw = 3; st[0].rww = 1;
    st[1] = st[0]; st[1].rwm = 0;
    st[2] = st[0]; st[2].rs1e = 0; st[2].rdm = 0; st[2].rdw = 0;
    st[3].rs1e = 7; st[3].rs2e = 7; st[3].rdm = 7; st[3].rwm = 1; st[3].rdw = 7; st[3].rww = 1;
    st[4].rs2e = 9; st[4].rdm = 9; st[4].rdw = 9; st[4].rww = 1;
    st[5].rs1e = 4; st[5].rs2e = 6; st[5].rdm = 6; st[5].rwm = 1; st[5].rdw = 4; st[5].rww = 1;
    fa = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    fb = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 6; i++) begin
      drive(st[i]); sb.push_back(E(C_RUN, fa[i], fb[i], 1'b0, 16'd2, 16'd1)); #2;
      got = obs(); e = sb.pop_front(); n_vec++;
      if (got !== e) begin n_miss++; $display("FAIL forward[%0d]: got=%h want=%h", i, got, e); end
    end
  endtask

  task automatic test_mem_wait();
    stim_t st[8]; exp_t ex[8]; exp_t got, e;
    foreach (st[i]) st[i] = '0;
    st[0].req = 1; st[0].pcsrc = 1;
    st[1].req = 1; st[1].pcsrc = 1; st[1].loade = 1; st[1].rde = 2; st[1].rs1d = 2;
    st[2].req = 1;
    st[3].req = 1; st[3].rdy = 1;
    st[5].pcsrc = 1;
    ex[0] = E(C_MEMW, 2'b00, 2'b00, 1'b0, 16'd2, 16'd1);
    ex[1] = E(C_MEMW, 2'b00, 2'b00, 1'b0, 16'd3, 16'd1);
    ex[2] = E(C_MEMW, 2'b00, 2'b00, 1'b0, 16'd4, 16'd1);
    ex[3] = E(C_RUN,  2'b00, 2'b00, 1'b0, 16'd5, 16'd1);
    ex[4] = E(C_RUN,  2'b00, 2'b00, 1'b0, 16'd5, 16'd1);
    ex[5] = E(C_BR,   2'b00, 2'b00, 1'b0, 16'd5, 16'd1);
    ex[6] = E(C_RUN,  2'b00, 2'b00, 1'b0, 16'd5, 16'd2);
    ex[7] = E(C_RUN,  2'b00, 2'b00, 1'b0, 16'd5, 16'd2);
    for (int i = 0; i < 8; i++) begin
      drive(st[i]); sb.push_back(ex[i]); #2;
      got = obs(); e = sb.pop_front(); n_vec++;
      if (got !== e) begin n_miss++; $display("FAIL mem_wait[%0d]: got=%h want=%h", i, got, e); end
    end
  endtask

  // Fifteen wait cycles is one short of the limit: must recover without timeout.
  task automatic test_long_wait();
    stim_t s; exp_t got, e;
    for (int i = 0; i < 17; i++) begin
      s = '0; s.req = (i < 16); s.rdy = (i == 15);
      drive(s);
      if (i < 15) sb.push_back(E(C_MEMW, 2'b00, 2'b00, 1'b0, 16'(5 + i), 16'd2));
      else        sb.push_back(E(C_RUN,  2'b00, 2'b00, 1'b0, 16'd20, 16'd2));
      #2;
      got = obs(); e = sb.pop_front(); n_vec++;
      if (got !== e) begin n_miss++; $display("FAIL long_wait[%0d]: got=%h want=%h", i, got, e); end
    end
  endtask

  task automatic test_timeout();
    stim_t s; exp_t got, e;
    for (int i = 0; i < 18; i++) begin
      s = '0; s.req = (i < 17); s.rdy = (i == 16); s.pcsrc = (i == 17);
      drive(s);
      if (i < 16) sb.push_back(E(C_MEMW, 2'b00, 2'b00, 1'b0, 16'(20 + i), 16'd2));
      else        sb.push_back(E(C_MEMW, 2'b00, 2'b00, 1'b1, 16'd36, 16'd2));
      #2;
      got = obs(); e = sb.pop_front(); n_vec++;
      if (got !== e) begin n_miss++; $display("FAIL timeout[%0d]: got=%h want=%h", i, got, e); end
    end
  endtask

  task automatic test_reset_midwait();
    stim_t st[11]; exp_t ex[11]; exp_t got, e;
    foreach (st[i]) begin st[i] = '0; ex[i] = E(C_START, 2'b00, 2'b00, 1'b0, 16'd0, 16'd0); end
    st[0].rst = 1;
    st[4].req = 1; st[5].req = 1; st[6].req = 1;
    st[7].rst = 1;
    ex[3] = E(C_RUN,  2'b00, 2'b00, 1'b0, 16'd0, 16'd0);
    ex[4] = E(C_MEMW, 2'b00, 2'b00, 1'b0, 16'd0, 16'd0);
    ex[5] = E(C_MEMW, 2'b00, 2'b00, 1'b0, 16'd1, 16'd0);
    ex[6] = E(C_MEMW, 2'b00, 2'b00, 1'b0, 16'd2, 16'd0);
    ex[10] = E(C_RUN, 2'b00, 2'b00, 1'b0, 16'd0, 16'd0);
    for (int i = 0; i < 11; i++) begin
      drive(st[i]); sb.push_back(ex[i]); #2;
      got = obs(); e = sb.pop_front(); n_vec++;
      if (got !== e) begin n_miss++; $display("FAIL reset_mid[%0d]: got=%h want=%h", i, got, e); end
      if (i == 6) begin
        // Assert reset between clock edges, with memory still waiting.
        #1 rst = 1'b1;
        sb.push_back(E(C_START, 2'b00, 2'b00, 1'b0, 16'd0, 16'd0)); #1;
        got = obs(); e = sb.pop_front(); n_vec++;
        if (got !== e) begin n_miss++; $display("FAIL reset_async: got=%h want=%h", got, e); end
      end
    end
  endtask

  task automatic test_saturate();
    stim_t s; exp_t got, e; logic [3:0] sat_got, sat_want;
    for (int i = 0; i < 11; i++) begin
      s = '0;
      if (i < 5) begin s.loade = 1; s.rde = 8; s.rs2d = 8; end
      else if (i < 10) s.pcsrc = 1;
      drive(s);
      sb.push_back(E((i < 5) ? C_LU : (i < 10) ? C_BR : C_RUN, 2'b00, 2'b00, 1'b0,
                     16'((i < 5) ? i : 5), 16'((i < 5) ? 0 : i - 5)));
      #2;
      got = obs(); e = sb.pop_front(); n_vec++;
      if (got !== e) begin n_miss++; $display("FAIL saturate[%0d]: got=%h want=%h", i, got, e); end
      sat_got  = {s_StallCnt, s_FlushCnt};
      sat_want = {2'((i < 3) ? i : 3), 2'((i < 5) ? 0 : (i < 8) ? i - 5 : 3)};
      n_vec++;
      if (sat_got !== sat_want) begin
        n_miss++; $display("FAIL sat_counts[%0d]: got=%b want=%b", i, sat_got, sat_want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_load_use();
    test_branch();
    test_forward();
    test_mem_wait();
    test_long_wait();
    test_timeout();
    test_reset_midwait();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=still running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage RV32I pipeline. It drives the stall and flush inputs of the F/D/E/M/W pipeline registers, including the D-to-E register's clr_i, and it drives the E-stage forwarding mux selects. It also sequences start-up after reset and freezes the pipeline on data-memory wait states, with a timeout. It keeps saturating stall and flush counters for performance debug.

Parameters:
REGISTER_ADDRESS_WIDTH, 5, register index width
STARTUP_CYCLES, 2, cycles after reset release during which the pipeline is held flushed
MAX_WAIT, 16, longest allowed data-memory wait in cycles before timeout
COUNT_WIDTH, 16, width of the performance counters

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
Rs1D_i, Rs2D_i  in  REGISTER_ADDRESS_WIDTH  source registers in D
Rs1E_i, Rs2E_i  in  REGISTER_ADDRESS_WIDTH  source registers in E
RdE_i, RdM_i, RdW_i  in  REGISTER_ADDRESS_WIDTH  destination registers in E/M/W
LoadE_i  in  1  instruction in E is a load (ResultSrcE==01)
RegWriteM_i, RegWriteW_i  in  1  register write enables in M/W
PCSrcE_i  in  1  branch taken or jump resolved in E
MemReqM_i  in  1  instruction in M accesses data memory
MemReadyM_i  in  1  data memory completes access this cycle
StallF_o, StallD_o, StallE_o, StallM_o  out  1  hold stage register
FlushD_o, FlushE_o, FlushW_o  out  1  insert bubble into F/D, D/E, M/W register
ForwardAE_o, ForwardBE_o  out  2  00 = regfile, 01 = W result, 10 = M ALU result
MemTimeout_o  out  1  sticky: memory wait exceeded MAX_WAIT
StallCount_o, FlushCount_o  out  COUNT_WIDTH  performance counters

Behaviour:
- Interface: one clock, clk_i. rst_i is asynchronous and active-high.
- Reset (rst_i=1):
  - state=STARTUP, startup counter=0, wait counter=0.
  - StallF=1, FlushD=FlushE=FlushW=1; all other stall outputs 0.
  - Forward selects 00, MemTimeout=0, both counters 0.
- FSM states: STARTUP, RUN, MEM_WAIT, HALT.
- STARTUP:
  - Outputs are the same as in reset.
  - Startup counter increments each cycle. Go to RUN after STARTUP_CYCLES cycles, so the first fetch register update happens in cycle STARTUP_CYCLES+1.
- RUN, outputs evaluated combinationally in this priority order:
  1. Memory wait (MemReqM_i & !MemReadyM_i): StallF/D/E/M=1, FlushW=1, no D/E flush. Go to MEM_WAIT, wait counter=1.
  2. PCSrcE_i: FlushD=1, FlushE=1, no stalls. This wins over load-use, because the instruction in D is on the wrong path.
  3. Load-use: LoadE_i & RdE_i!=0 & (RdE_i==Rs1D_i | RdE_i==Rs2D_i). Then StallF=1, StallD=1, FlushE=1 (single-cycle bubble).
  4. Otherwise all stall and flush outputs are 0.
- MEM_WAIT:
  - StallF/D/E/M=1 and FlushW=1; PCSrcE_i and load-use are ignored while E is frozen. The wait counter increments each cycle.
  - If MemReadyM_i=1: stalls deassert combinationally in that same cycle, return to RUN, wait counter=0.
  - If the wait counter reaches MAX_WAIT without MemReadyM_i: set MemTimeout_o and go to HALT.
- HALT:
  - StallF/D/E/M=1 and FlushW=1 permanently.
  - Exit only through rst_i.
- Forwarding (combinational, in every state):
  - ForwardAE=10 if RegWriteM_i & RdM_i!=0 & RdM_i==Rs1E_i.
  - Otherwise 01 if RegWriteW_i & RdW_i!=0 & RdW_i==Rs1E_i.
  - Otherwise 00.
  - ForwardBE uses the same rule with Rs2E_i. M has priority over W.
- Counters:
  - StallCount increments on each cycle StallD_o=1 in RUN or MEM_WAIT.
  - FlushCount increments on each cycle of a PCSrcE flush in RUN.
  - Both saturate at all-ones; STARTUP and HALT cycles are not counted.
- Reset asserted mid-MEM_WAIT: immediate return to STARTUP, counters cleared.

Test Plan:
- Release reset, STARTUP_CYCLES=2 -> FlushE=1 and StallF=1 for 2 cycles, then all 0 in RUN. Counters stay 0.
- In RUN: LoadE=1, RdE=5, Rs1D=5 -> one cycle of StallF=StallD=FlushE=1, StallCount=1. Same case with RdE=0 -> no stall.
- LoadE=1, RdE=5, Rs2D=5 with PCSrcE=1 in the same cycle -> FlushD=FlushE=1, StallD=0, FlushCount=1, StallCount=0.
- Forwarding: Rs1E=3, RdM=3, RegWriteM=1, RdW=3, RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> 01. Set Rs1E=0 -> 00.
- MemReqM=1, MemReady low for 3 cycles then high -> stalls and FlushW high for 3 cycles, low in the ready cycle. StallCount=3, back to RUN.
- MemReady held low for MAX_WAIT=16 cycles -> MemTimeout_o=1 and stalls stuck high. Assert rst_i mid-wait on a second run -> immediate STARTUP outputs, MemTimeout=0.
